// File: rtl/ro_slot_scheduler.sv
// -----------------------------------------------------------------------------
// ro_slot_scheduler
//
// Time-multiplexes the eve / pol_eve event bits of N_CH readout channels onto a
// single serial pair. A binary frame counter advances on every enabled cycle.
// Its Gray-coded image is exported, and the Gray bit that toggles on a given
// step picks the channel that owns that cycle. Channel k therefore gets one
// slot every 2^(k+1) cycles. The all-zero wrap step is an idle slot that marks
// the frame boundary.
//
// Events that arrive between a channel's slots are kept in per-channel sticky
// pending latches. A second event that lands on an already-pending latch,
// outside that channel's slot, is lost. Such a loss is recorded in a sticky
// overflow flag.
//
// Ports
//   clk_master       in   1       master clock, rising edge
//   reset            in   1       synchronous, active-high reset
//   en               in   1       advance counter / issue slots
//   in_eve           in   N_CH    per-channel event strobes
//   in_pol_eve       in   N_CH    per-channel polarity-event strobes
//   ovf_clr          in   1       clear all overflow flags
//   gray_count       out  N_CH    registered Gray code of the frame counter
//   out_mux_eve      out  1       eve bit of the served channel
//   out_mux_pol_eve  out  1       pol_eve bit of the served channel
//   out_valid        out  1       outputs carry a channel slot
//   slot_id          out  SLOT_W  index of the served channel
//   frame_start      out  1       one-cycle pulse on the idle (wrap) slot
//   overflow         out  N_CH    sticky per-channel event-loss flags
// -----------------------------------------------------------------------------
module ro_slot_scheduler #(
    parameter int N_CH   = 8,
    parameter int SLOT_W = 3
) (
    input  logic              clk_master,
    input  logic              reset,
    input  logic              en,
    input  logic [N_CH-1:0]   in_eve,
    input  logic [N_CH-1:0]   in_pol_eve,
    input  logic              ovf_clr,
    output logic [N_CH-1:0]   gray_count,
    output logic              out_mux_eve,
    output logic              out_mux_pol_eve,
    output logic              out_valid,
    output logic [SLOT_W-1:0] slot_id,
    output logic              frame_start,
    output logic [N_CH-1:0]   overflow
);

    // Index of the lowest set bit. This is the Gray bit that toggles when the
    // binary counter steps to v. It is only meaningful for v != 0.
    function automatic logic [SLOT_W-1:0] trailing_zeros(input logic [N_CH-1:0] v);
        logic [SLOT_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SLOT_W'(i);
            end
        end
        return idx;
    endfunction

    // Registered state
    logic [N_CH-1:0]   cnt_q,   cnt_d;
    logic [N_CH-1:0]   gray_q,  gray_d;
    logic [N_CH-1:0]   pe_q,    pe_d;
    logic [N_CH-1:0]   pp_q,    pp_d;
    logic [N_CH-1:0]   ovf_q,   ovf_d;
    logic              eve_q,   eve_d;
    logic              pol_q,   pol_d;
    logic              valid_q, valid_d;
    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic              fs_q,    fs_d;

    // Slot decode helpers
    logic [N_CH-1:0]   cnt_inc;
    logic              wrap;
    logic              serve;
    logic [SLOT_W-1:0] serve_ch;
    logic [N_CH-1:0]   serve_mask;
    logic [N_CH-1:0]   eve_merge;
    logic [N_CH-1:0]   pol_merge;
    logic [N_CH-1:0]   ovf_set;

    always_comb begin
        cnt_inc    = cnt_q + N_CH'(1);
        wrap       = (cnt_inc == '0);
        serve      = en && !wrap;
        serve_ch   = trailing_zeros(cnt_inc);
        serve_mask = serve ? (N_CH'(1) << serve_ch) : '0;

        // A strobe arriving in its own channel's slot is merged into the
        // outgoing bit, so the served bit and the latch update share one OR.
        eve_merge  = pe_q | in_eve;
        pol_merge  = pp_q | in_pol_eve;

        // Counter and Gray image hold while en is low. Because of this, a
        // stall neither skips nor repeats a slot.
        cnt_d  = en ? cnt_inc : cnt_q;
        gray_d = en ? (cnt_inc ^ (cnt_inc >> 1)) : gray_q;

        // Pending latches run every cycle, independent of en. Only the served
        // channel is drained.
        pe_d = eve_merge & ~serve_mask;
        pp_d = pol_merge & ~serve_mask;

        // An event is lost when it hits an already-set latch that is not being
        // drained this cycle. A new loss wins over a simultaneous clear.
        ovf_set = ((in_eve & pe_q) | (in_pol_eve & pp_q)) & ~serve_mask;
        ovf_d   = ovf_set | (ovf_clr ? '0 : ovf_q);

        valid_d = 1'b0;
        fs_d    = 1'b0;
        eve_d   = 1'b0;
        pol_d   = 1'b0;
        slot_d  = slot_q;
        if (en) begin
            if (wrap) begin
                fs_d   = 1'b1;
                slot_d = '0;
            end else begin
                valid_d = 1'b1;
                slot_d  = serve_ch;
                eve_d   = |(eve_merge & serve_mask);
                pol_d   = |(pol_merge & serve_mask);
            end
        end
    end

    always_ff @(posedge clk_master) begin
        if (reset) begin
            cnt_q   <= '0;
            gray_q  <= '0;
            pe_q    <= '0;
            pp_q    <= '0;
            ovf_q   <= '0;
            eve_q   <= 1'b0;
            pol_q   <= 1'b0;
            valid_q <= 1'b0;
            slot_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            pe_q    <= pe_d;
            pp_q    <= pp_d;
            ovf_q   <= ovf_d;
            eve_q   <= eve_d;
            pol_q   <= pol_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
            fs_q    <= fs_d;
        end
    end

    assign gray_count      = gray_q;
    assign out_mux_eve     = eve_q;
    assign out_mux_pol_eve = pol_q;
    assign out_valid       = valid_q;
    assign slot_id         = slot_q;
    assign frame_start     = fs_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for ro_slot_scheduler, built with N_CH=4 and SLOT_W=2.
// A frame table holds the reset step followed by one full frame of slots. Short
// hand-written sequences then cover the event, overflow, reset and stall cases.
// -----------------------------------------------------------------------------
module tb_ro_slot_scheduler;

    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk_master = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  in_eve;
    logic [N-1:0]  in_pol_eve;
    logic          ovf_clr;
    logic [N-1:0]  gray_count;
    logic          out_mux_eve;
    logic          out_mux_pol_eve;
    logic          out_valid;
    logic [SW-1:0] slot_id;
    logic          frame_start;
    logic [N-1:0]  overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk_master = ~clk_master;

    ro_slot_scheduler #(.N_CH(N), .SLOT_W(SW)) dut (
        .clk_master      (clk_master),
        .reset           (reset),
        .en              (en),
        .in_eve          (in_eve),
        .in_pol_eve      (in_pol_eve),
        .ovf_clr         (ovf_clr),
        .gray_count      (gray_count),
        .out_mux_eve     (out_mux_eve),
        .out_mux_pol_eve (out_mux_pol_eve),
        .out_valid       (out_valid),
        .slot_id         (slot_id),
        .frame_start     (frame_start),
        .overflow        (overflow)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic [N-1:0]  ev;
        logic [N-1:0]  pv;
        logic          clr;
        logic [N-1:0]  gray;
        logic          oe;
        logic          op;
        logic          ov;
        logic [SW-1:0] sl;
        logic          fs;
        logic [N-1:0]  of;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic rst, logic e, logic [N-1:0] ev, logic [N-1:0] pv,
                                logic clr, logic [N-1:0] g, logic oe, logic op,
                                logic ov, logic [SW-1:0] sl, logic fs, logic [N-1:0] of);
        vec_t v;
        v.rst = rst; v.en = e; v.ev = ev; v.pv = pv; v.clr = clr;
        v.gray = g; v.oe = oe; v.op = op; v.ov = ov; v.sl = sl; v.fs = fs; v.of = of;
        return v;
    endfunction

    // Drive one cycle of inputs and sample the outputs 1 time unit after the edge.
    task automatic step(logic r, logic e, logic [N-1:0] ev, logic [N-1:0] pv, logic c);
        reset = r; en = e; in_eve = ev; in_pol_eve = pv; ovf_clr = c;
        @(posedge clk_master);
        #1;
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic check(string name, logic [N-1:0] g, logic e, logic p, logic v,
                         logic [SW-1:0] s, logic f, logic [N-1:0] o);
        checks++;
        if ({gray_count, out_mux_eve, out_mux_pol_eve, out_valid, slot_id, frame_start, overflow}
            !== {g, e, p, v, s, f, o}) begin
            failures++;
            $display("FAIL %s: got gray=%b eve=%b pol=%b valid=%b slot=%0d fs=%b ovf=%b ; want gray=%b eve=%b pol=%b valid=%b slot=%0d fs=%b ovf=%b",
                     name, gray_count, out_mux_eve, out_mux_pol_eve, out_valid, slot_id,
                     frame_start, overflow, g, e, p, v, s, f, o);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; in_eve = '0; in_pol_eve = '0; ovf_clr = 1'b0;

        //          rst   en    ev       pv       clr   gray     oe    op    ov    sl     fs    of
        vecs[0]  = mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        vecs[1]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[2]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
        vecs[3]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[4]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000);
        vecs[5]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[6]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
        vecs[7]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[8]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);
        vecs[9]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[10] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
        vecs[11] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[12] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000);
        vecs[13] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[14] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
        vecs[15] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        vecs[16] = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000);

        // Reset followed by one full frame with no events.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ev, vecs[i].pv, vecs[i].clr);
            check($sformatf("frame[%0d]", i), vecs[i].gray, vecs[i].oe, vecs[i].op,
                  vecs[i].ov, vecs[i].sl, vecs[i].fs, vecs[i].of);
        end

        // eve[3] pulse at cnt=1 is held until the ch3 slot at cnt 7->8.
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle_steps(1);                                    // cnt 0->1
        step(1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0);         // cnt 1->2, latch ch3
        idle_steps(5);                                    // cnt 2->7
        check("ch3_pending_held", 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        idle_steps(1);                                    // cnt 7->8
        check("ch3_served", 4'b1100, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);
        idle_steps(16);                                   // next ch3 slot
        check("ch3_next_empty", 4'b1100, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);

        // pol[2] pulsed twice before ch2 is served -> overflow, then clear tests.
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0);         // cnt 0->1
        check("pol2_first", 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0);         // cnt 1->2
        check("pol2_overflow", 4'b0011, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0100);
        idle_steps(1);                                    // cnt 2->3
        idle_steps(1);                                    // cnt 3->4, ch2
        check("pol2_served", 4'b0110, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100);
        step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);         // cnt 4->5, clear
        check("ovf_clear", 4'b0111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0);         // cnt 5->6, latch
        step(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1);         // cnt 6->7, set + clr
        check("ovf_set_beats_clr", 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0100);

        // eve[0] strobe in the exact cycle ch0 is served.
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);         // cnt 0->1, ch0
        check("ch0_same_cycle", 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        idle_steps(2);                                    // cnt 1->3
        check("ch0_cleared", 4'b0010, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);

        // Reset mid-frame discards pending events on ch1 and ch2.
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle_steps(4);                                    // cnt 0->4
        step(1'b0, 1'b1, 4'b0110, 4'b0110, 1'b0);         // cnt 4->5, latch
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);         // reset at cnt 5
        check("midframe_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
        idle_steps(1);
        check("post_reset_ch0", 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        idle_steps(1);
        check("post_reset_ch1", 4'b0011, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);

        // en low for 3 cycles at cnt=6, with an eve[1] pulse during the stall.
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        idle_steps(6);                                    // cnt 0->6
        step(1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0);
        check("stall_1", 4'b0101, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check("stall_2", 4'b0101, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check("stall_3", 4'b0101, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000);
        idle_steps(1);
        check("resume_ch0", 4'b0100, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        idle_steps(1);
        check("resume_ch3", 4'b1100, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);
        idle_steps(1);
        check("resume_ch0b", 4'b1101, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
        idle_steps(1);
        check("resume_ch1_event", 4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ro_slot_scheduler.md
Name: ro_slot_scheduler

Overview:
- Time-multiplexes the eve/pol_eve event bits of N_CH readout channels onto one shared serial pair (out_mux_eve, out_mux_pol_eve).
- Slots come from a Gray-coded frame counter. Channel k owns the cycle in which Gray bit k toggles, so channel k is served once every 2^(k+1) cycles and channel 0 is the fastest.
- Events that arrive between slots are held in per-channel sticky latches. Lost events are flagged.
- The block sits between the per-core event sources and the chip readout pins. It replaces free-running tri-state slot gating with a single synchronous scheduler.

Parameters:
- N_CH, 8, number of channels and Gray counter width.
- SLOT_W, 3, width of slot_id. Constraint: 2^SLOT_W >= N_CH.

Ports:
- clk_master  input  1  master clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance the counter and issue slots when high.
- in_eve  input  N_CH  per-channel event strobe; each cycle high counts as one event.
- in_pol_eve  input  N_CH  per-channel polarity-event strobe, independent of in_eve.
- ovf_clr  input  1  clears all overflow flags.
- gray_count  output  N_CH  registered Gray code of the frame counter.
- out_mux_eve  output  1  serialized eve bit of the served channel.
- out_mux_pol_eve  output  1  serialized pol_eve bit of the served channel.
- out_valid  output  1  high when the outputs carry a channel slot.
- slot_id  output  SLOT_W  index of the served channel.
- frame_start  output  1  one-cycle pulse on the idle (wrap) slot.
- overflow  output  N_CH  sticky per-channel event-loss flags.

Behaviour:
- Reset (synchronous, takes priority over everything): cnt, gray_count, pending latches, overflow, out_mux_eve, out_mux_pol_eve, out_valid, slot_id and frame_start all go to 0.
- Counter:
  - cnt is an N_CH-bit binary register.
  - When en=1 at an edge: cnt <= cnt+1, wrapping modulo 2^N_CH. gray_count <= g ^ (g>>1), where g = cnt+1.
  - When en=0: cnt and gray_count hold.
- Slot selection (en=1, current cnt=c, n=c+1 mod 2^N_CH):
  - If n != 0: s = number of trailing zeros of n, which is the Gray bit that toggles. Channel s is served.
  - If n == 0: idle slot.
- Pending latches (pe[k], pp[k]) are updated every cycle regardless of en:
  - Default: pe[k] <= pe[k] | in_eve[k], and likewise for pp[k].
  - Served channel s: out_mux_eve <= pe[s] | in_eve[s] (a same-cycle strobe is merged and not lost). Same for pol. Then pe[s] <= 0 and pp[s] <= 0.
- Output registers, latency one cycle:
  - After the edge, gray_count, slot_id and the outputs all refer to the same slot.
  - Served slot: out_valid <= 1, slot_id <= s, frame_start <= 0.
  - Idle slot: out_valid <= 0, out_mux_* <= 0, slot_id <= 0, frame_start <= 1.
  - en=0: out_valid <= 0, frame_start <= 0, out_mux_* <= 0, slot_id holds.
- Overflow:
  - overflow[k] <= 1 when in_eve[k] or in_pol_eve[k] is high, the matching pending bit is already 1, and channel k is not served this cycle.
  - Set has priority over ovf_clr in the same cycle. Otherwise ovf_clr clears all flags.
- Frame period is 2^N_CH cycles. Channel k gets 2^(N_CH-k-1) slots per frame.
- Reset asserted mid-frame: all pending events are discarded, and the next enabled cycle serves channel 0.
- Toggling en never skips or repeats a slot; the sequence resumes from the held cnt.

Test Plan:
- N_CH=4, reset, then en=1 with no events for 16 cycles -> slot_id sequence 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0 with out_valid=1, then an idle cycle with frame_start=1 and out_valid=0. Exactly one gray_count bit changes per cycle: 0001,0011,0010,0110,...,1000,0000.
- One-cycle in_eve[3] pulse at cnt=1 -> pending held until the first ch3 slot (cnt=7->8), where out_mux_eve=1 and slot_id=3. overflow stays 0. The next ch3 slot gives out_mux_eve=0.
- in_pol_eve[2] pulsed twice before ch2 is served -> overflow[2]=1, out_mux_pol_eve=1 once. ovf_clr then clears the flag. ovf_clr coinciding with a new overflow event -> flag remains 1.
- in_eve[0] high in the exact cycle channel 0 is served, with pe[0]=0 -> out_mux_eve=1 on the next cycle, pending cleared, no overflow.
- Events on channels 1 and 2 pending, reset asserted at cnt=5 -> all outputs and flags 0. The first post-reset slot is channel 0 with out_mux_*=0.
- en low for 3 cycles at cnt=6 -> out_valid=0 and gray_count frozen at 0101. An in_eve[1] pulse during the stall is latched. On resume the next slot is channel 0 (cnt 6->7), then channel 3 (cnt 7->8), then channel 0 (cnt 8->9), then channel 1 (cnt 9->10) with out_mux_eve=1.
